// File: rtl/bcdu_instr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcdu_instr_arbiter_if : sequencer-side and BCDU-side arbiter signals     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bcdu_instr_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int INSTR_W = 16
);
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ-1:0]         i_instr_valid;
  logic [N_REQ*INSTR_W-1:0] i_instr;
  logic                     i_bcdu_ready;
  logic [N_REQ-1:0]         o_accept;
  logic [N_REQ-1:0]         o_grant;
  logic                     o_instr_valid;
  logic [INSTR_W-1:0]       o_instr;
  logic                     o_busy;
  logic                     o_proto_err;

  modport master (
    output i_req, i_instr_valid, i_instr, i_bcdu_ready,
    input  o_accept, o_grant, o_instr_valid, o_instr, o_busy, o_proto_err
  );

  modport slave (
    input  i_req, i_instr_valid, i_instr, i_bcdu_ready,
    output o_accept, o_grant, o_instr_valid, o_instr, o_busy, o_proto_err
  );
endinterface
`default_nettype wire

// File: rtl/bcdu_instr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcdu_instr_arbiter : round-robin, sequence-locked BCDU instruction port  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcdu_instr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int INSTR_W = 16
) (
  input wire logic             i_clk,
  input wire logic             i_rst_n,
  bcdu_instr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [3:0] BCDU_OP_NOP = 4'h0;
  localparam logic [INSTR_W-1:0] NOP_WORD = {BCDU_OP_NOP, {(INSTR_W-4){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 proto_err_q, proto_err_d;

  logic                 owned;
  logic                 release_w;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       cand;
  logic [N_REQ-1:0]     grant_w;
  logic [INSTR_W-1:0]   instr_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign instr_arr[k] = bus.i_instr[k*INSTR_W +: INSTR_W];
  end

  // The owner is always the last winner, so last_q doubles as the owner index.
  assign owned     = (state_q == S_OWNED);
  assign release_w = owned && !bus.i_req[last_q] && !bus.i_instr_valid[last_q];
  assign grant_w   = owned ? ({{(N_REQ-1){1'b0}}, 1'b1} << last_q) : '0;

  // Cyclic search upward from last+1; the previous winner is visited last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!win_found && bus.i_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    instr_valid_d = 1'b0;
    instr_d       = NOP_WORD;
    proto_err_d   = proto_err_q;

    if ((!owned || release_w) && win_found) begin
      state_d = S_OWNED;
      last_d  = win_idx;
    end else if (release_w) begin
      state_d = S_IDLE;
    end

    if (owned && bus.i_instr_valid[last_q]) begin
      instr_valid_d = 1'b1;
      instr_d       = instr_arr[last_q];
    end

    // Valid from a non-owner is dropped and latched as an error.
    if (|(bus.i_instr_valid & ~grant_w)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      last_q        <= IDX_W'(N_REQ-1);
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_WORD;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bus.o_grant       = grant_w;
  assign bus.o_accept      = grant_w & {N_REQ{bus.i_bcdu_ready}};
  assign bus.o_busy        = owned;
  assign bus.o_instr_valid = instr_valid_q;
  assign bus.o_instr       = instr_q;
  assign bus.o_proto_err   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcdu_instr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcdu_instr_arbiter : directed stimulus with a scoreboard on BCDU port |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bcdu_instr_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam logic [W-1:0] NOP = 16'h0000;
  localparam logic [W-1:0] SHL = 16'h5012;
  localparam logic [W-1:0] CMP = 16'h6034;
  localparam logic [W-1:0] ADD = 16'h1056;
  localparam logic [W-1:0] CLR = 16'h7000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] exp_q [$];

  bcdu_instr_arbiter_if #(.N_REQ(N), .INSTR_W(W)) bus ();

  bcdu_instr_arbiter #(.N_REQ(N), .INSTR_W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [W-1:0] w, input logic push);
    bus.i_instr_valid[k]   = 1'b1;
    bus.i_instr[k*W +: W]  = w;
    if (push) exp_q.push_back(w);
  endtask

  // Monitor: every BCDU issue must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_instr_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_unexpected: got %0h with no expected word", bus.o_instr);
        end else begin
          chk("issue_word", 32'(bus.o_instr), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_word_nop", 32'(bus.o_instr), 32'(NOP));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.i_req          = '0;
    bus.i_instr_valid  = '0;
    bus.i_instr        = '0;
    bus.i_bcdu_ready   = 1'b1;
    tick();
    tick();
    chk("rst_grant",  32'(bus.o_grant), 0);
    chk("rst_busy",   32'(bus.o_busy), 0);
    chk("rst_accept", 32'(bus.o_accept), 0);
    chk("rst_ivalid", 32'(bus.o_instr_valid), 0);
    chk("rst_instr",  32'(bus.o_instr), 32'(NOP));
    chk("rst_err",    32'(bus.o_proto_err), 0);
    rst_n = 1'b1;

    // Asynchronous reset while requester 1 owns the port with an issue in flight.
    bus.i_req = 4'b0010;
    tick();
    chk("r1_grant",  32'(bus.o_grant), 32'h2);
    chk("r1_busy",   32'(bus.o_busy), 1);
    chk("r1_accept", 32'(bus.o_accept), 32'h2);
    drive(1, 16'hA111, 1'b0);
    tick();
    chk("r1_inflight", 32'(bus.o_instr_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_grant",  32'(bus.o_grant), 0);
    chk("arst_busy",   32'(bus.o_busy), 0);
    chk("arst_ivalid", 32'(bus.o_instr_valid), 0);
    chk("arst_instr",  32'(bus.o_instr), 32'(NOP));
    bus.i_instr_valid = '0;
    bus.i_req         = 4'b0011;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_r0_first", 32'(bus.o_grant), 32'h1);
    bus.i_req = '0;
    tick();
    chk("post_rst_idle", 32'(bus.o_grant), 0);

    // Single requester, four-instruction sequence; last one trails i_req.
    bus.i_req = 4'b0001;
    tick();
    chk("single_grant", 32'(bus.o_grant), 32'h1);
    drive(0, SHL, 1'b1); tick();
    drive(0, CMP, 1'b1); tick();
    drive(0, ADD, 1'b1); tick();
    bus.i_req[0] = 1'b0;
    drive(0, CLR, 1'b1); tick();
    chk("single_hold_tail", 32'(bus.o_grant), 32'h1);
    bus.i_instr_valid = '0;
    tick();
    chk("single_release", 32'(bus.o_grant), 0);
    chk("single_release_busy", 32'(bus.o_busy), 0);

    // Round-robin with all requesting; reset so requester 0 starts.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_owner", 32'(bus.o_grant), 32'(1 << (i % N)));
      drive(i % N, 16'hB000 | 16'(i), 1'b1);
      tick();
      bus.i_instr_valid   = '0;
      bus.i_req[i % N]    = 1'b0;
      tick();
      bus.i_req[i % N]    = 1'b1;
      chk("rr_next_no_bubble", 32'(bus.o_grant), 32'(1 << ((i + 1) % N)));
      chk("rr_busy", 32'(bus.o_busy), 1);
    end
    bus.i_req = '0;
    tick();
    chk("rr_idle", 32'(bus.o_grant), 0);

    // Lock: requester 0 arrives while 2 is mid-sequence.
    bus.i_req = 4'b0100;
    tick();
    chk("lock_grant2", 32'(bus.o_grant), 32'h4);
    drive(2, 16'h2A01, 1'b1);
    bus.i_req = 4'b0101;
    #1;
    chk("lock_accept", 32'(bus.o_accept), 32'h4);
    tick();
    drive(2, 16'h2A02, 1'b1);
    tick();
    chk("lock_hold", 32'(bus.o_grant), 32'h4);
    bus.i_instr_valid = '0;
    tick();
    chk("lock_hold2", 32'(bus.o_grant), 32'h4);
    bus.i_req = 4'b0001;
    tick();
    chk("lock_handoff", 32'(bus.o_grant), 32'h1);
    bus.i_req = '0;
    tick();
    chk("lock_idle", 32'(bus.o_grant), 0);

    // Backpressure on owner 1.
    bus.i_req = 4'b0010;
    tick();
    foreach (exp_q[i]) ;
    for (int i = 0; i < 4; i++) begin
      bus.i_bcdu_ready = (i == 0 || i == 3);
      #1;
      chk("bp_accept", 32'(bus.o_accept), (i == 0 || i == 3) ? 32'h2 : 32'h0);
      chk("bp_grant",  32'(bus.o_grant), 32'h2);
      tick();
    end
    chk("bp_no_err", 32'(bus.o_proto_err), 0);
    bus.i_bcdu_ready = 1'b1;
    bus.i_req        = '0;
    tick();
    chk("bp_idle", 32'(bus.o_grant), 0);

    // Protocol error: non-owner 3 presents valid while 0 owns.
    bus.i_req = 4'b0001;
    tick();
    chk("pe_grant", 32'(bus.o_grant), 32'h1);
    chk("pe_clear", 32'(bus.o_proto_err), 0);
    drive(0, 16'hC0DE, 1'b1);
    drive(3, 16'hDEAD, 1'b0);
    tick();
    chk("pe_set", 32'(bus.o_proto_err), 1);
    bus.i_instr_valid = '0;
    bus.i_req         = '0;
    tick();
    chk("pe_sticky1", 32'(bus.o_proto_err), 1);
    tick();
    chk("pe_sticky2", 32'(bus.o_proto_err), 1);

    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcdu_instr_arbiter.md
# bcdu_instr_arbiter

Shares the single BCDU instruction port between up to `N_REQ` sequencers (add/sub, mul, div, conversion). Each sequencer holds its request for a whole instruction sequence, so the arbiter grants round-robin and locks the grant until that sequence drains. While locked, it gates the BCDU accept strobe back to the owner and registers the owner's instruction onto the BCDU port.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `INSTR_W`, 16: instruction width; matches the BCDU instruction word.

Ports:
- `i_clk`  in  1  clock; all registers are clocked on the rising edge.
- `i_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_req`  in  `N_REQ`  per-requester sequence request; the requester holds it high from start until its sequence ends.
- `i_instr_valid`  in  `N_REQ`  per-requester instruction valid.
- `i_instr`  in  `N_REQ*INSTR_W`  per-requester instruction; requester k occupies bits `[k*INSTR_W +: INSTR_W]`.
- `i_bcdu_ready`  in  1  BCDU can take an instruction this cycle.
- `o_accept`  out  `N_REQ`  per-requester instruction accept; the requester's `i_instr_accept`.
- `o_grant`  out  `N_REQ`  one-hot current owner; all zero when no owner.
- `o_instr_valid`  out  1  registered instruction valid to the BCDU.
- `o_instr`  out  `INSTR_W`  registered instruction to the BCDU.
- `o_busy`  out  1  a grant is held.
- `o_proto_err`  out  1  sticky protocol-error flag.

## Operation
- States:
  - **IDLE**: `o_grant` = 0.
  - **OWNED**: `o_grant` is one-hot owner g.
- **Arbitration.** Happens at a clock edge when the state is IDLE, or when the owner releases, and `i_req` is nonzero.
  - Winner: the first set bit of `i_req` searching upward, cyclically, from `last+1`, where `last` is the previous winner index.
  - `last` resets to `N_REQ-1`, so requester 0 has first priority after reset.
  - The winner is recorded into `last`.
- **Release.** In OWNED, the owner releases when `i_req[g]`=0 and `i_instr_valid[g]`=0 in the same cycle. This lets the last instruction, issued the cycle after the requester's `i_req` falls, still pass through.
  - At the release edge: if another `i_req` bit is set, re-arbitrate and grant directly with no bubble; otherwise go to IDLE.
  - The released requester is eligible again but has lowest priority.
- **Accept.** `o_accept[k]` = `o_grant[k] & i_bcdu_ready`. This path is combinational, with no added cycle.
- **Instruction register.** Each edge:
  - `o_instr_valid` <= `i_instr_valid[g]` when OWNED, else 0.
  - `o_instr` <= `i_instr[g]` when OWNED and valid, else `{BCDU_OP_NOP, 12'b0}` from `bcdu_op_codes.vh`.
- **Protocol error.** `o_proto_err` is set, and held until reset, when `i_instr_valid[k]`=1 for any k with `o_grant[k]`=0. That instruction is dropped and is never forwarded.
- `o_busy` = (state == OWNED).

## Timing
- Reset values:
  - state IDLE; `last` = `N_REQ-1`.
  - `o_grant` 0, `o_busy` 0, `o_accept` 0.
  - `o_instr_valid` 0, `o_instr` = NOP word, `o_proto_err` 0.
- Asynchronous reset mid-sequence drops the grant immediately; any in-flight instruction is discarded.
- Grant latency: `i_req[k]` rises before edge t from IDLE → `o_grant[k]` and `o_busy` are high after edge t. `o_accept[k]` can be high in that same cycle.
- Instruction latency: `i_instr_valid[g]` in cycle n → `o_instr_valid` in cycle n+1. Exactly one BCDU issue occurs per requester valid cycle.
- Simultaneous requests: exactly one winner per arbitration edge; losers keep `i_req` high and are not accepted.
- The owner dropping `i_req` while its `i_instr_valid` is still high keeps the grant one more cycle. Release happens at the first cycle with both low.
- `i_bcdu_ready` low: `o_accept` is all zero; the grant is held; no error.
- `i_req` of non-owners may toggle freely; only their valid bits matter for the error flag.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-cycle with `i_req`=4'b0010 granted → `o_grant`, `o_busy`, `o_instr_valid` go to 0 asynchronously; `o_instr`=NOP; after release, requester 0 wins first if requesting.
- **Single requester:** `i_req`=4'b0001, `i_bcdu_ready`=1; the requester issues SHL, CMP, ADD, CLR on consecutive cycles → `o_grant`=0001 one edge after `i_req`; four `o_instr_valid` pulses, each one cycle after its input and with identical words; grant released the first cycle `i_req[0]`=0 and `i_instr_valid[0]`=0.
- **Round-robin:** `i_req`=4'b1111 held, each owner issuing one instruction then releasing → grant order 0,1,2,3,0; no idle cycle between grants.
- **Lock:** owner 2 is mid-sequence and requester 0 raises `i_req` → `o_accept[0]`=0 and `o_grant` stays 0100 until requester 2 releases; then 0001.
- **Backpressure:** owner 1 with `i_bcdu_ready` toggling 1,0,0,1 → `o_accept[1]` follows `i_bcdu_ready` exactly; the grant is held throughout.
- **Protocol error:** `i_instr_valid[3]`=1 while `o_grant`=0001 → `o_proto_err`=1 from the next edge and stays 1; `o_instr` carries only requester 0's words or NOP.
